// File: rtl/capture_scheduler_if.sv
// Scheduler bundle: vsync, capture controls, writer handshake, consumer mailbox and status.
// The master modport is the scheduler side. The slave modport is the writer/consumer/host side.
interface capture_scheduler_if;
    logic        vsync_n;
    logic        start_single;
    logic        cont_en;
    logic        stop;
    logic        capture_sig;
    logic        capture_rtn;
    logic [31:0] wr_base;
    logic        frame_valid;
    logic [31:0] frame_base;
    logic        frame_take;
    logic        frame_release;
    logic        busy;
    logic        err;
    logic [15:0] frames_done;
    logic [15:0] frames_dropped;

    modport master (
        input  vsync_n, start_single, cont_en, stop, capture_rtn, frame_take, frame_release,
        output capture_sig, wr_base, frame_valid, frame_base, busy, err, frames_done, frames_dropped
    );

    modport slave (
        output vsync_n, start_single, cont_en, stop, capture_rtn, frame_take, frame_release,
        input  capture_sig, wr_base, frame_valid, frame_base, busy, err, frames_done, frames_dropped
    );
endinterface

// File: rtl/capture_scheduler.sv
// Frame-capture sequencer with triple-buffer rotation and a take/release mailbox for the consumer.
// Buffers are assigned so that the writer never targets the latest or the held frame.
module capture_scheduler #(
    parameter int          NUM_BUF     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'd7680000
) (
    input  logic                  vid_clk,
    input  logic                  rst,
    capture_scheduler_if.master   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    function automatic logic [31:0] buf_base(input logic [1:0] idx);
        return BASE_ADDR + 32'(idx) * FRAME_BYTES;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  vs_q, vs_d;
    logic        single_q, single_d;
    logic        stop_pend_q, stop_pend_d;
    logic        capture_sig_q, capture_sig_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  latest_idx_q, latest_idx_d;
    logic [1:0]  held_idx_q, held_idx_d;
    logic        latest_vld_q, latest_vld_d;
    logic        held_vld_q, held_vld_d;
    logic [31:0] wr_base_q, wr_base_d;
    logic [31:0] frame_base_q, frame_base_d;
    logic [15:0] frames_done_q, frames_done_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;
    logic [NUM_BUF-1:0] buf_free;

    logic vs_rise, frame_end, run_frame_end, take;

    // capture_rtn still reflects the frame that just ended during the vs_rise cycle
    assign vs_rise       = vs_q[0] & ~vs_q[1];
    assign frame_end     = vs_rise & bus.capture_rtn;
    assign run_frame_end = frame_end && (state_q == ST_RUN);
    assign take          = bus.frame_take & latest_vld_q;

    always_comb begin
        vs_d         = {vs_q[0], ~bus.vsync_n};
        latest_vld_d = latest_vld_q;
        latest_idx_d = latest_idx_q;
        held_vld_d   = held_vld_q;
        held_idx_d   = held_idx_q;
        if (take) begin
            held_vld_d   = 1'b1;
            held_idx_d   = latest_idx_q;
            latest_vld_d = 1'b0;
        end else if (bus.frame_release) begin
            held_vld_d = 1'b0;
        end
        if (run_frame_end) begin
            latest_vld_d = 1'b1;
            latest_idx_d = wr_idx_q;
        end
        frame_base_d = buf_base(latest_idx_d);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUF; gi++) begin : g_free
            assign buf_free[gi] = (latest_idx_d != 2'(gi)) && !(held_vld_d && (held_idx_d == 2'(gi)));
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        single_d         = single_q;
        stop_pend_d      = stop_pend_q;
        capture_sig_d    = capture_sig_q;
        err_d            = err_q;
        wr_idx_d         = wr_idx_q;
        frames_done_d    = frames_done_q;
        frames_dropped_d = frames_dropped_q;
        if (run_frame_end) begin
            frames_done_d = frames_done_q + 16'd1;
            if (latest_vld_q && !take)
                frames_dropped_d = frames_dropped_q + 16'd1;
            // descending scan so the lowest free index is the one that sticks
            for (int i = NUM_BUF - 1; i >= 0; i--)
                if (buf_free[i]) wr_idx_d = 2'(i);
        end
        wr_base_d = buf_base(wr_idx_d);
        case (state_q)
            ST_IDLE: begin
                stop_pend_d   = 1'b0;
                capture_sig_d = 1'b0;
                if (bus.start_single) begin
                    single_d      = 1'b1;
                    state_d       = ST_ARM;
                    capture_sig_d = 1'b1;
                end else if (bus.cont_en) begin
                    single_d      = 1'b0;
                    state_d       = ST_ARM;
                    capture_sig_d = 1'b1;
                end
            end
            ST_ARM: begin
                if (vs_rise) begin
                    state_d       = ST_RUN;
                    stop_pend_d   = bus.stop;
                    capture_sig_d = bus.cont_en && !single_q && !bus.stop;
                end else if (bus.stop || (!single_q && !bus.cont_en)) begin
                    capture_sig_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_RUN: begin
                stop_pend_d   = stop_pend_q | bus.stop;
                capture_sig_d = bus.cont_en && !single_q && !stop_pend_d;
                if (vs_rise && !bus.capture_rtn) begin
                    err_d         = 1'b1;
                    state_d       = ST_IDLE;
                    capture_sig_d = 1'b0;
                end else if (frame_end && !capture_sig_q) begin
                    state_d       = ST_IDLE;
                    capture_sig_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            vs_q             <= 2'b00;
            single_q         <= 1'b0;
            stop_pend_q      <= 1'b0;
            capture_sig_q    <= 1'b0;
            err_q            <= 1'b0;
            busy_q           <= 1'b0;
            wr_idx_q         <= 2'd0;
            latest_idx_q     <= 2'd0;
            held_idx_q       <= 2'd0;
            latest_vld_q     <= 1'b0;
            held_vld_q       <= 1'b0;
            wr_base_q        <= BASE_ADDR;
            frame_base_q     <= BASE_ADDR;
            frames_done_q    <= 16'd0;
            frames_dropped_q <= 16'd0;
        end else begin
            state_q          <= state_d;
            vs_q             <= vs_d;
            single_q         <= single_d;
            stop_pend_q      <= stop_pend_d;
            capture_sig_q    <= capture_sig_d;
            err_q            <= err_d;
            busy_q           <= busy_d;
            wr_idx_q         <= wr_idx_d;
            latest_idx_q     <= latest_idx_d;
            held_idx_q       <= held_idx_d;
            latest_vld_q     <= latest_vld_d;
            held_vld_q       <= held_vld_d;
            wr_base_q        <= wr_base_d;
            frame_base_q     <= frame_base_d;
            frames_done_q    <= frames_done_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign bus.capture_sig    = capture_sig_q;
    assign bus.wr_base        = wr_base_q;
    assign bus.frame_valid    = latest_vld_q;
    assign bus.frame_base     = frame_base_q;
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;
    assign bus.frames_done    = frames_done_q;
    assign bus.frames_dropped = frames_dropped_q;
endmodule
